// File: rtl/id_slice.sv
// Decode stage: IF/ID register, 16-entry register file with write-through bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_slice #(
   parameter int DATA_W = 16,
   parameter int RA_W   = 4,
   parameter int IMM_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr_in,
   input  logic [15:0]       PC_inc_in,
   input  logic              flush,
   input  logic              ex_memrd,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              id_valid,
   output logic [15:0]       id_PC_inc,
   output logic [3:0]        id_opcode,
   output logic [RA_W-1:0]   id_rd,
   output logic [RA_W-1:0]   id_rs,
   output logic [RA_W-1:0]   id_rt,
   output logic [DATA_W-1:0] id_rs_data,
   output logic [DATA_W-1:0] id_rt_data,
   output logic [DATA_W-1:0] id_imm
);

   localparam int NREG = 1 << RA_W;

   logic [15:0]       ifid_instr;
   logic [15:0]       ifid_pc_inc;
   logic              ifid_valid;

   logic [3:0]        opcode;
   logic [RA_W-1:0]   rd;
   logic [RA_W-1:0]   rs;
   logic [RA_W-1:0]   rt;
   logic [DATA_W-1:0] imm;
   logic              reads_rt;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifid_instr  <= '0;
         ifid_pc_inc <= '0;
         ifid_valid  <= 1'b0;
      end else if (flush) begin
         ifid_instr  <= '0;
         ifid_valid  <= 1'b0;
      end else if (!stall) begin
         ifid_instr  <= instr_in;
         ifid_pc_inc <= PC_inc_in;
         ifid_valid  <= 1'b1;
      end
   end

   assign opcode   = ifid_instr[15:12];
   assign rd       = ifid_instr[8 +: RA_W];
   assign rs       = ifid_instr[4 +: RA_W];
   assign rt       = ifid_instr[0 +: RA_W];
   assign imm      = {{(DATA_W-IMM_W){ifid_instr[IMM_W-1]}}, ifid_instr[IMM_W-1:0]};
   assign reads_rt = ~opcode[3];

   // A load in EX whose destination feeds this instruction must delay it one cycle.
   always_comb begin
      stall = 1'b0;
      if (!flush && ifid_valid && ex_memrd && (ex_rd != '0)) begin
         if ((ex_rd == rs) || (reads_rt && (ex_rd == rt))) begin
            stall = 1'b1;
         end
      end
   end

   // Reads see a same-cycle writeback so decode never picks up a stale value.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (rs != '0) begin
         rs_data = (wb_we && (wb_rd == rs)) ? wb_data : regs[rs];
      end
      if (rt != '0) begin
         rt_data = (wb_we && (wb_rd == rt)) ? wb_data : regs[rt];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_we && (wb_rd != '0)) begin
         regs[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid   <= 1'b0;
         id_PC_inc  <= '0;
         id_opcode  <= '0;
         id_rd      <= '0;
         id_rs      <= '0;
         id_rt      <= '0;
         id_rs_data <= '0;
         id_rt_data <= '0;
         id_imm     <= '0;
      end else if (flush || stall || !ifid_valid) begin
         id_valid   <= 1'b0;
         id_PC_inc  <= '0;
         id_opcode  <= '0;
         id_rd      <= '0;
         id_rs      <= '0;
         id_rt      <= '0;
         id_rs_data <= '0;
         id_rt_data <= '0;
         id_imm     <= '0;
      end else begin
         id_valid   <= 1'b1;
         id_PC_inc  <= ifid_pc_inc;
         id_opcode  <= opcode;
         id_rd      <= rd;
         id_rs      <= rs;
         id_rt      <= rt;
         id_rs_data <= rs_data;
         id_rt_data <= rt_data;
         id_imm     <= imm;
      end
   end

endmodule

// File: tb/tb_id_slice.sv
// Directed bench for id_slice: bypass, load-use stall, flush, R0 and reset behaviour.
module tb_id_slice;

   logic        clk;
   logic        rst;
   logic [15:0] instr_in;
   logic [15:0] PC_inc_in;
   logic        flush;
   logic        ex_memrd;
   logic [3:0]  ex_rd;
   logic        wb_we;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        stall;
   logic        id_valid;
   logic [15:0] id_PC_inc;
   logic [3:0]  id_opcode;
   logic [3:0]  id_rd;
   logic [3:0]  id_rs;
   logic [3:0]  id_rt;
   logic [15:0] id_rs_data;
   logic [15:0] id_rt_data;
   logic [15:0] id_imm;

   int compared;
   int mismatched;

   id_slice dut (
      .clk        (clk),
      .rst        (rst),
      .instr_in   (instr_in),
      .PC_inc_in  (PC_inc_in),
      .flush      (flush),
      .ex_memrd   (ex_memrd),
      .ex_rd      (ex_rd),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .stall      (stall),
      .id_valid   (id_valid),
      .id_PC_inc  (id_PC_inc),
      .id_opcode  (id_opcode),
      .id_rd      (id_rd),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_data (id_rs_data),
      .id_rt_data (id_rt_data),
      .id_imm     (id_imm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc);
      instr_in  = instr;
      PC_inc_in = pc;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b0;
      flush      = 1'b0;
      ex_memrd   = 1'b0;
      ex_rd      = 4'h0;
      wb_we      = 1'b0;
      wb_rd      = 4'h0;
      wb_data    = 16'h0;
      applyStimulus(16'h0000, 16'h0000);

      cycle();
      cycle();
      checkOutput("reset_valid", {31'b0, id_valid}, 32'h0);
      checkOutput("reset_stall", {31'b0, stall}, 32'h0);
      checkOutput("reset_pc", {16'b0, id_PC_inc}, 32'h0);
      rst = 1'b1;

      // Bypass: R3 written in the same cycle ID reads rs=3
      applyStimulus(16'h8130, 16'h0011);
      cycle();
      wb_we = 1'b1; wb_rd = 4'h3; wb_data = 16'hBEEF;
      applyStimulus(16'h0000, 16'h0012);
      cycle();
      checkOutput("bypass_rs_data", {16'b0, id_rs_data}, 32'h0000BEEF);
      checkOutput("bypass_valid", {31'b0, id_valid}, 32'h1);
      checkOutput("bypass_pc", {16'b0, id_PC_inc}, 32'h0011);
      checkOutput("bypass_fields", {16'b0, id_opcode, id_rd, id_rs, id_rt}, 32'h8130);
      checkOutput("bypass_imm", {16'b0, id_imm}, 32'h0030);

      wb_rd = 4'h5; wb_data = 16'h5555;
      cycle();
      wb_rd = 4'h2; wb_data = 16'h2222;
      cycle();
      wb_we = 1'b0;

      // Load-use on rt
      applyStimulus(16'h2125, 16'h0020);
      cycle();
      ex_memrd = 1'b1; ex_rd = 4'h5;
      applyStimulus(16'h3000, 16'h0021);
      #1;
      checkOutput("lu_stall", {31'b0, stall}, 32'h1);
      cycle();
      checkOutput("lu_bubble", {31'b0, id_valid}, 32'h0);
      checkOutput("lu_bubble_op", {28'b0, id_opcode}, 32'h0);
      ex_memrd = 1'b0;
      #1;
      checkOutput("lu_stall_clear", {31'b0, stall}, 32'h0);
      cycle();
      checkOutput("lu_held_valid", {31'b0, id_valid}, 32'h1);
      checkOutput("lu_held_fields", {16'b0, id_opcode, id_rd, id_rs, id_rt}, 32'h2125);
      checkOutput("lu_held_pc", {16'b0, id_PC_inc}, 32'h0020);
      checkOutput("lu_rs_data", {16'b0, id_rs_data}, 32'h2222);
      checkOutput("lu_rt_data", {16'b0, id_rt_data}, 32'h5555);

      // rt unused for opcodes 8-F; rs match still stalls; ex_rd=0 never stalls
      applyStimulus(16'h9125, 16'h0030);
      cycle();
      ex_memrd = 1'b1; ex_rd = 4'h5;
      #1;
      checkOutput("nort_stall", {31'b0, stall}, 32'h0);
      ex_rd = 4'h2;
      #1;
      checkOutput("rs_stall", {31'b0, stall}, 32'h1);
      ex_memrd = 1'b0;
      cycle();
      checkOutput("nort_valid", {31'b0, id_valid}, 32'h1);
      checkOutput("nort_fields", {16'b0, id_opcode, id_rd, id_rs, id_rt}, 32'h9125);
      applyStimulus(16'h2100, 16'h0031);
      cycle();
      ex_memrd = 1'b1; ex_rd = 4'h0;
      #1;
      checkOutput("exrd0_stall", {31'b0, stall}, 32'h0);
      ex_memrd = 1'b0;

      // Flush coincident with a stall condition
      applyStimulus(16'h2125, 16'h0040);
      cycle();
      ex_memrd = 1'b1; ex_rd = 4'h5; flush = 1'b1;
      #1;
      checkOutput("flush_stall", {31'b0, stall}, 32'h0);
      cycle();
      flush = 1'b0;
      checkOutput("flush_idex", {31'b0, id_valid}, 32'h0);
      #1;
      checkOutput("flush_ifid_stall", {31'b0, stall}, 32'h0);
      ex_memrd = 1'b0;
      cycle();
      checkOutput("flush_ifid_bubble", {31'b0, id_valid}, 32'h0);
      cycle();
      checkOutput("flush_recover", {31'b0, id_valid}, 32'h1);

      // R0 ignores writes; immediate sign extension
      applyStimulus(16'h8104, 16'h0050);
      wb_we = 1'b1; wb_rd = 4'h0; wb_data = 16'h1234;
      cycle();
      cycle();
      wb_we = 1'b0;
      checkOutput("r0_read", {16'b0, id_rs_data}, 32'h0);
      applyStimulus(16'h8AF6, 16'h0077);
      cycle();
      cycle();
      checkOutput("imm_sext", {16'b0, id_imm}, 32'hFFF6);
      checkOutput("imm_rd", {28'b0, id_rd}, 32'hA);
      checkOutput("imm_fields", {16'b0, id_opcode, id_rd, id_rs, id_rt}, 32'h8AF6);
      checkOutput("imm_pc", {16'b0, id_PC_inc}, 32'h0077);

      // Reset mid-stream
      applyStimulus(16'h8130, 16'h0088);
      cycle();
      cycle();
      checkOutput("pre_reset_r3", {16'b0, id_rs_data}, 32'hBEEF);
      ex_memrd = 1'b1; ex_rd = 4'h3;
      rst = 1'b0;
      #1;
      checkOutput("mid_reset_valid", {31'b0, id_valid}, 32'h0);
      checkOutput("mid_reset_stall", {31'b0, stall}, 32'h0);
      checkOutput("mid_reset_rs_data", {16'b0, id_rs_data}, 32'h0);
      ex_memrd = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      checkOutput("post_reset_edge1", {31'b0, id_valid}, 32'h0);
      cycle();
      checkOutput("post_reset_edge2", {31'b0, id_valid}, 32'h1);
      checkOutput("post_reset_r3", {16'b0, id_rs_data}, 32'h0);
      for (int i = 1; i < 16; i++) begin
         applyStimulus({4'h8, 4'h0, 4'(i), 4'h0}, 16'h0100);
         cycle();
         cycle();
         checkOutput($sformatf("post_reset_r%0d", i), {16'b0, id_rs_data}, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
